// File: rtl/fp_special_stage.sv
// Front stage of the FP square-root pipeline: classifies each operand, resolves its
// special-case result, and hands it downstream through a 2-entry skid buffer.
module fp_special_stage #(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned MANT_W = 10,
    parameter int unsigned FTZ    = 0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              is_nan,
    output logic              is_pinf,
    output logic              is_zero,
    output logic              is_normal,
    output logic              is_subnormal,
    output logic              invalid,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_out,
    input  logic              clr_flags,
    output logic              flag_invalid,
    output logic [CNT_W-1:0]  invalid_cnt
);

    localparam logic [EXP_W-1:0]  EMAX    = {EXP_W{1'b1}};
    localparam logic [MANT_W-1:0] QBIT    = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic              is_nan;
        logic              is_pinf;
        logic              is_zero;
        logic              is_normal;
        logic              is_subnormal;
        logic              invalid;
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } entry_t;

    entry_t            res_c;
    entry_t            head_q, head_d;
    entry_t            skid_q, skid_d;
    logic              head_v_q, head_v_d;
    logic              skid_v_q, skid_v_d;
    logic              in_ready_q, in_ready_d;
    logic              flag_q, flag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_c, pop_c;
    logic              exp_zero_c, exp_max_c, mant_zero_c;

    assign exp_zero_c  = (exp_in == '0);
    assign exp_max_c   = (exp_in == EMAX);
    assign mant_zero_c = (mant_in == '0);

    // Special-case resolution; NaN is tested first so negative NaNs stay NaNs.
    always_comb begin
        res_c      = '0;
        res_c.sign = sign_in;
        res_c.exp  = exp_in;
        res_c.mant = mant_in;
        if (exp_max_c && !mant_zero_c) begin
            res_c.is_nan  = 1'b1;
            res_c.mant    = mant_in | QBIT;
            res_c.invalid = ~mant_in[MANT_W-1];
        end else if (exp_zero_c && mant_zero_c) begin
            res_c.is_zero = 1'b1;
        end else if (exp_zero_c && (FTZ != 0)) begin
            res_c.is_zero = 1'b1;
            res_c.exp     = '0;
            res_c.mant    = '0;
        end else if (sign_in) begin
            res_c.is_nan  = 1'b1;
            res_c.invalid = 1'b1;
            res_c.sign    = 1'b1;
            res_c.exp     = EMAX;
            res_c.mant    = QBIT;
        end else if (exp_max_c) begin
            res_c.is_pinf = 1'b1;
        end else if (exp_zero_c) begin
            res_c.is_subnormal = 1'b1;
        end else begin
            res_c.is_normal = 1'b1;
        end
    end

    assign push_c = enable & in_valid & in_ready_q;
    assign pop_c  = enable & head_v_q & out_ready;

    // Skid buffer: the skid entry always drains into the head before new pushes are taken.
    always_comb begin
        head_d   = head_q;
        head_v_d = head_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (skid_v_q) begin
            if (pop_c) begin
                head_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (push_c) begin
            if (!head_v_q || pop_c) begin
                head_d   = res_c;
                head_v_d = 1'b1;
            end else begin
                skid_d   = res_c;
                skid_v_d = 1'b1;
            end
        end else if (pop_c) begin
            head_v_d = 1'b0;
        end
        in_ready_d = ~skid_v_d;
    end

    // A new invalid event takes priority over a coincident clear.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (push_c && res_c.invalid) begin
            flag_d = 1'b1;
            if (clr_flags) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (enable && clr_flags) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            head_v_q   <= 1'b0;
            skid_q     <= '0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            flag_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            head_q     <= head_d;
            head_v_q   <= head_v_d;
            skid_q     <= skid_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            flag_q     <= flag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q & enable;
    assign out_valid    = head_v_q;
    assign is_nan       = head_q.is_nan;
    assign is_pinf      = head_q.is_pinf;
    assign is_zero      = head_q.is_zero;
    assign is_normal    = head_q.is_normal;
    assign is_subnormal = head_q.is_subnormal;
    assign invalid      = head_q.invalid;
    assign sign_out     = head_q.sign;
    assign exp_out      = head_q.exp;
    assign mant_out     = head_q.mant;
    assign flag_invalid = flag_q;
    assign invalid_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_special_stage.sv
// Scoreboard bench for fp_special_stage: one FP16 instance with defaults (u0) and one
// with FTZ=1, CNT_W=2 (u1), both driven by the same operand stream.
module tb_fp_special_stage;

    localparam logic [4:0] C_NAN  = 5'b10000;
    localparam logic [4:0] C_PINF = 5'b01000;
    localparam logic [4:0] C_ZERO = 5'b00100;
    localparam logic [4:0] C_NORM = 5'b00010;
    localparam logic [4:0] C_SUB  = 5'b00001;

    typedef struct packed {
        logic [15:0] in;
        logic [15:0] e0; logic [4:0] c0; logic i0;
        logic [15:0] e1; logic [4:0] c1; logic i1;
    } vec_t;

    typedef struct packed {
        logic [15:0] word;
        logic [4:0]  cls;
        logic        inv;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, in_valid = 1'b0, out_ready = 1'b1, clr_flags = 1'b0;
    logic sign_in = 1'b0;
    logic [4:0] exp_in = '0;
    logic [9:0] mant_in = '0;

    logic in_ready0, ov0, nan0, pinf0, zero0, norm0, sub0, inv0, s0, flag0;
    logic [4:0] e0; logic [9:0] m0; logic [7:0] cnt0;
    logic in_ready1, ov1, nan1, pinf1, zero1, norm1, sub1, inv1, s1, flag1;
    logic [4:0] e1; logic [9:0] m1; logic [1:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    fp_special_stage u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready0),
        .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .out_valid(ov0), .out_ready(out_ready),
        .is_nan(nan0), .is_pinf(pinf0), .is_zero(zero0), .is_normal(norm0), .is_subnormal(sub0),
        .invalid(inv0), .sign_out(s0), .exp_out(e0), .mant_out(m0), .clr_flags(clr_flags),
        .flag_invalid(flag0), .invalid_cnt(cnt0));

    fp_special_stage #(.FTZ(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready1),
        .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .out_valid(ov1), .out_ready(out_ready),
        .is_nan(nan1), .is_pinf(pinf1), .is_zero(zero1), .is_normal(norm1), .is_subnormal(sub1),
        .invalid(inv1), .sign_out(s1), .exp_out(e1), .mant_out(m1), .clr_flags(clr_flags),
        .flag_invalid(flag1), .invalid_cnt(cnt1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitors: a transfer happens at the next rising edge when these hold at the falling edge.
    always @(negedge clk) begin
        if (rst_n && enable && ov0 && out_ready) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q0.pop_front();
                check("u0_word", 32'({s0, e0, m0}), 32'(x.word));
                check("u0_class", 32'({nan0, pinf0, zero0, norm0, sub0}), 32'(x.cls));
                check("u0_invalid", 32'(inv0), 32'(x.inv));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && enable && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q1.pop_front();
                check("u1_word", 32'({s1, e1, m1}), 32'(x.word));
                check("u1_class", 32'({nan1, pinf1, zero1, norm1, sub1}), 32'(x.cls));
                check("u1_invalid", 32'(inv1), 32'(x.inv));
            end
        end
    end

    // Tasks start and end one time unit after a rising edge.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        {sign_in, exp_in, mant_in} = v.in;
        forever begin
            @(negedge clk);
            if (in_ready0) begin
                q0.push_back({v.e0, v.c0, v.i0});
                q1.push_back({v.e1, v.c1, v.i1});
                @(posedge clk); #1;
                break;
            end
            n++;
            if (n > 50) begin
                check("send_timeout", 32'd1, 32'd0);
                @(posedge clk); #1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_q0_empty", 32'(q0.size()), 32'd0);
        check("drain_q1_empty", 32'(q1.size()), 32'd0);
    endtask

    vec_t v_one, v_ninf, v_snan, v_nzero, v_pinf, v_nsub, v_psub, v_qnan, v_big;

    initial begin
        v_one   = '{16'h3C00, 16'h3C00, C_NORM, 1'b0, 16'h3C00, C_NORM, 1'b0};
        v_ninf  = '{16'hFC00, 16'hFE00, C_NAN,  1'b1, 16'hFE00, C_NAN,  1'b1};
        v_snan  = '{16'h7D00, 16'h7F00, C_NAN,  1'b1, 16'h7F00, C_NAN,  1'b1};
        v_nzero = '{16'h8000, 16'h8000, C_ZERO, 1'b0, 16'h8000, C_ZERO, 1'b0};
        v_pinf  = '{16'h7C00, 16'h7C00, C_PINF, 1'b0, 16'h7C00, C_PINF, 1'b0};
        v_nsub  = '{16'h8001, 16'hFE00, C_NAN,  1'b1, 16'h8000, C_ZERO, 1'b0};
        v_psub  = '{16'h0001, 16'h0001, C_SUB,  1'b0, 16'h0000, C_ZERO, 1'b0};
        v_qnan  = '{16'hFE01, 16'hFE01, C_NAN,  1'b0, 16'hFE01, C_NAN,  1'b0};
        v_big   = '{16'h7BFF, 16'h7BFF, C_NORM, 1'b0, 16'h7BFF, C_NORM, 1'b0};

        #12;
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd1);
        check("rst_word", 32'({s0, e0, m0}), 32'd0);
        check("rst_class", 32'({nan0, pinf0, zero0, norm0, sub0, inv0}), 32'd0);
        check("rst_flags", 32'({flag0, cnt0, flag1, cnt1}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        send(v_one);
        check("latency_out_valid", 32'(ov0), 32'd1);
        send(v_ninf);
        check("ninf_flag", 32'({flag0, flag1}), 32'b11);
        check("ninf_cnt0", 32'(cnt0), 32'd1);
        send(v_snan);
        check("snan_cnt0", 32'(cnt0), 32'd2);
        check("snan_cnt1", 32'(cnt1), 32'd2);
        send(v_nzero);
        send(v_pinf);
        send(v_nsub);
        send(v_psub);
        send(v_qnan);
        drain();
        check("phaseA_cnt0", 32'(cnt0), 32'd3);
        check("phaseA_cnt1", 32'(cnt1), 32'd2);

        // Back-pressure: two entries fill head and skid, the third waits.
        out_ready = 1'b0;
        send(v_one);
        send(v_psub);
        check("stall_in_ready_low", 32'(in_ready0), 32'd0);
        fork
            send(v_pinf);
            begin
                idle(2);
                check("stall_out_valid_held", 32'(ov0), 32'd1);
                check("stall_word_held", 32'({s0, e0, m0}), 32'h3C00);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_in_ready_back", 32'(in_ready0), 32'd1);

        // Stage enable low freezes everything even with out_ready high.
        out_ready = 1'b0;
        send(v_big);
        enable = 1'b0;
        out_ready = 1'b1;
        idle(3);
        check("disable_in_ready", 32'(in_ready0), 32'd0);
        check("disable_out_valid", 32'(ov0), 32'd1);
        check("disable_queue_held", 32'(q0.size()), 32'd1);
        enable = 1'b1;
        drain();

        // Counter saturation on the 2-bit instance.
        send(v_ninf);
        send(v_ninf);
        send(v_ninf);
        check("sat_cnt1", 32'(cnt1), 32'd3);
        check("sat_cnt0", 32'(cnt0), 32'd6);
        clr_flags = 1'b1;
        send(v_ninf);
        clr_flags = 1'b0;
        check("clr_evt_cnt0", 32'(cnt0), 32'd1);
        check("clr_evt_cnt1", 32'(cnt1), 32'd1);
        check("clr_evt_flags", 32'({flag0, flag1}), 32'b11);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        check("clr_only", 32'({flag0, cnt0, flag1, cnt1}), 32'd0);
        drain();

        // Reset mid-stream discards buffered entries.
        out_ready = 1'b0;
        send(v_one);
        send(v_ninf);
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        check("midrst_out_valid", 32'({ov0, ov1}), 32'd0);
        check("midrst_flags", 32'({flag0, cnt0}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("midrst_in_ready", 32'(in_ready0), 32'd1);
        send(v_big);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
